// File: rtl/uart_csr_bridge.sv
// UART-to-CSR bridge: parses command frames from received bytes, performs one CSR
// access per frame and answers with 8'hAA (write) or four read-data bytes, MSB first.
module uart_csr_bridge #(
  parameter int unsigned timeout = 1000000
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [7:0]  tx_data,
  output logic        tx_wr,
  input  logic        tx_done,
  output logic [13:0] csr_a,
  output logic        csr_we,
  output logic [31:0] csr_di,
  input  logic [31:0] csr_do,
  output logic        busy,
  output logic        overrun
);

  localparam int unsigned TW = (timeout > 1) ? $clog2(timeout) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(timeout - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, WDATA, CSR_WR, CSR_RD, CSR_CAP, TX_SEND, TX_WAIT
  } state_e;

  state_e        state_q;
  logic          we_q;
  logic [13:0]   addr_q;
  logic [31:0]   data_q;
  logic [2:0]    cnt_q;
  logic [TW-1:0] tmo_q;
  logic          overrun_q;
  logic [7:0]    tx_data_q;
  logic          tx_wr_q;
  logic [13:0]   csr_a_q;
  logic          csr_we_q;
  logic [31:0]   csr_di_q;

  logic in_frame;
  logic tmo_hit;
  logic unused_rx_bit6;

  assign in_frame       = (state_q == ADDR) || (state_q == WDATA);
  assign tmo_hit        = in_frame && (tmo_q == TMO_LAST);
  assign unused_rx_bit6 = rx_data[6];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      overrun_q <= 1'b0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      csr_a_q   <= '0;
      csr_we_q  <= 1'b0;
      csr_di_q  <= '0;
    end else begin
      // Strobes and the CSR bus default to idle; each state raises them for one cycle.
      tx_wr_q  <= 1'b0;
      csr_we_q <= 1'b0;
      csr_a_q  <= '0;
      csr_di_q <= '0;

      if (!in_frame || rx_done) tmo_q <= '0;
      else                      tmo_q <= tmo_q + 1'b1;

      if (rx_done && !in_frame && (state_q != IDLE)) overrun_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (rx_done) begin
            we_q         <= rx_data[7];
            addr_q[13:8] <= rx_data[5:0];
            state_q      <= ADDR;
          end
        end
        ADDR: begin
          // A timeout beats a byte arriving in the same cycle.
          if (tmo_hit) begin
            state_q <= IDLE;
          end else if (rx_done) begin
            addr_q[7:0] <= rx_data;
            cnt_q       <= '0;
            if (we_q) begin
              state_q <= WDATA;
            end else begin
              csr_a_q <= {addr_q[13:8], rx_data};
              state_q <= CSR_RD;
            end
          end
        end
        WDATA: begin
          if (tmo_hit) begin
            state_q <= IDLE;
          end else if (rx_done) begin
            data_q <= {data_q[23:0], rx_data};
            cnt_q  <= cnt_q + 3'd1;
            if (cnt_q == 3'd3) begin
              csr_we_q <= 1'b1;
              csr_a_q  <= addr_q;
              csr_di_q <= {data_q[23:0], rx_data};
              state_q  <= CSR_WR;
            end
          end
        end
        CSR_WR: begin
          data_q  <= 32'hAA00_0000;
          cnt_q   <= 3'd1;
          state_q <= TX_SEND;
        end
        CSR_RD: state_q <= CSR_CAP;
        CSR_CAP: begin
          data_q  <= csr_do;
          cnt_q   <= 3'd4;
          state_q <= TX_SEND;
        end
        TX_SEND: begin
          tx_wr_q   <= 1'b1;
          tx_data_q <= data_q[31:24];
          data_q    <= {data_q[23:0], 8'h00};
          state_q   <= TX_WAIT;
        end
        TX_WAIT: begin
          if (tx_done) begin
            cnt_q   <= cnt_q - 3'd1;
            state_q <= (cnt_q == 3'd1) ? IDLE : TX_SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data = tx_data_q;
  assign tx_wr   = tx_wr_q;
  assign csr_a   = csr_a_q;
  assign csr_we  = csr_we_q;
  assign csr_di  = csr_di_q;
  assign busy    = (state_q != IDLE);
  assign overrun = overrun_q;

endmodule

// File: tb/tb_uart_csr_bridge.sv
// Randomized bench for uart_csr_bridge: frame-level reference model with a CSR memory,
// a UART transmitter responder and directed timeout, overrun and reset scenarios.
module tb_uart_csr_bridge;

  localparam int unsigned TMO = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic [7:0]  tx_data;
  logic        tx_wr;
  logic        tx_done;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;
  logic        busy;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] slave_mem [16384];
  logic [31:0] exp_mem   [16384];
  logic [7:0]  txq[$];
  logic [45:0] wr_log[$];
  int          acc_cyc = 0;
  int          done_cnt = 0;
  int          tx_overlap = 0;
  int          idle_di_bad = 0;
  bit          tx_pending = 1'b0;
  int          tx_delay = 0;
  logic [13:0] slv_a;

  uart_csr_bridge #(.timeout(TMO)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_done   (tx_done),
    .csr_a     (csr_a),
    .csr_we    (csr_we),
    .csr_di    (csr_di),
    .csr_do    (csr_do),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // CSR slave: the address seen in one cycle selects the read data of the next cycle.
  initial begin : csr_slave
    csr_do = 32'h0;
    forever begin
      @(negedge sys_clk);
      slv_a = csr_a;
      if (csr_we === 1'b1) begin
        slave_mem[slv_a] = csr_di;
        wr_log.push_back({slv_a, csr_di});
      end else if (csr_di !== 32'h0) begin
        idle_di_bad++;
      end
      if (csr_we === 1'b1 || csr_a !== 14'h0) acc_cyc++;
      @(posedge sys_clk);
      #1 csr_do = slave_mem[slv_a];
    end
  end

  // UART transmitter: acknowledges each byte after a random delay, plus stray tx_done pulses.
  initial begin : tx_resp
    tx_done = 1'b0;
    forever begin
      @(negedge sys_clk);
      tx_done = 1'b0;
      if (tx_wr === 1'b1) begin
        if (tx_pending) tx_overlap++;
        txq.push_back(tx_data);
        tx_pending = 1'b1;
        tx_delay   = $urandom_range(4, 0);
      end else if (tx_pending) begin
        if (tx_delay == 0) begin
          tx_done    = 1'b1;
          tx_pending = 1'b0;
          done_cnt++;
        end else begin
          tx_delay--;
        end
      end else if ($urandom_range(7, 0) == 0) begin
        tx_done = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge sys_clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge sys_clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
  endtask

  // d = cycles between the previous byte's rx_done and this one (d >= 2).
  task automatic send_gap(input logic [7:0] b, input int d);
    repeat (d - 2) @(negedge sys_clk);
    send_byte(b);
  endtask

  task automatic clear_logs();
    txq      = {};
    wr_log   = {};
    acc_cyc  = 0;
    done_cnt = 0;
  endtask

  task automatic wait_idle(input string tag, input int exp_done);
    int n = 0;
    while (busy === 1'b1 && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check({tag, " busy_falls"}, 64'(busy), 64'(0));
    check({tag, " done_at_idle"}, 64'(done_cnt), 64'(exp_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},    64'(busy),    64'(0));
    check({tag, " overrun"}, 64'(overrun), 64'(0));
    check({tag, " tx_wr"},   64'(tx_wr),   64'(0));
    check({tag, " tx_data"}, 64'(tx_data), 64'(0));
    check({tag, " csr_we"},  64'(csr_we),  64'(0));
    check({tag, " csr_a"},   64'(csr_a),   64'(0));
    check({tag, " csr_di"},  64'(csr_di),  64'(0));
  endtask

  // One complete frame checked against the frame-level model.
  task automatic run_frame(input string tag, input bit we, input bit x6, input logic [13:0] a,
                           input logic [31:0] d, input int glo, input int ghi);
    logic [7:0]  bytes[$];
    logic [31:0] exp_rd;
    bytes = {};
    bytes.push_back({we, x6, a[13:8]});
    bytes.push_back(a[7:0]);
    if (we) for (int i = 3; i >= 0; i--) bytes.push_back(d[8*i +: 8]);
    clear_logs();
    foreach (bytes[i]) send_gap(bytes[i], int'($urandom_range(ghi, glo)));
    wait_idle(tag, we ? 1 : 4);
    repeat (2) @(negedge sys_clk);
    check({tag, " acc_cycles"}, 64'(acc_cyc), 64'((we || a != 14'h0) ? 1 : 0));
    if (we) begin
      exp_mem[a] = d;
      check({tag, " wr_count"}, 64'(wr_log.size()), 64'(1));
      if (wr_log.size() > 0) check({tag, " wr_addr_data"}, 64'(wr_log[0]), 64'({a, d}));
      check({tag, " tx_count"}, 64'(txq.size()), 64'(1));
      if (txq.size() > 0) check({tag, " tx_ack"}, 64'(txq[0]), 64'(8'hAA));
    end else begin
      exp_rd = exp_mem[a];
      check({tag, " wr_count"}, 64'(wr_log.size()), 64'(0));
      check({tag, " tx_count"}, 64'(txq.size()), 64'(4));
      for (int i = 0; i < 4 && i < txq.size(); i++)
        check({tag, " rd_byte"}, 64'(txq[i]), 64'(exp_rd[8*(3-i) +: 8]));
    end
  endtask

  initial begin : main
    logic [13:0] ra;
    logic [31:0] rd;
    int n;
    for (int i = 0; i < 16384; i++) begin
      slave_mem[i] = $urandom;
      exp_mem[i]   = slave_mem[i];
    end
    sys_rst_n = 1'b0;
    rx_done   = 1'b0;
    rx_data   = 8'h00;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("rst_init");
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    run_frame("wr_0004", 1'b1, 1'b0, 14'h0004, 32'h1234_5678, 2, 2);

    slave_mem[14'h3FFF] = 32'hDEAD_BEEF;
    exp_mem[14'h3FFF]   = 32'hDEAD_BEEF;
    run_frame("rd_3fff", 1'b0, 1'b0, 14'h3FFF, 32'h0, 2, 2);

    for (int k = 0; k < 40; k++) begin
      ra = ($urandom_range(3, 0) == 0) ? 14'($urandom) : 14'($urandom_range(7, 0));
      run_frame("rand", 1'($urandom), 1'($urandom), ra, $urandom, 2, 6);
    end
    check("overrun_quiet", 64'(overrun), 64'(0));

    // Partial write frame abandoned after the idle limit.
    clear_logs();
    send_gap(8'h80, 2);
    send_gap(8'h00, 2);
    send_gap(8'h11, 2);
    repeat (20) @(negedge sys_clk);
    check("tmo busy", 64'(busy), 64'(0));
    check("tmo no_write", 64'(wr_log.size()), 64'(0));
    check("tmo no_access", 64'(acc_cyc), 64'(0));
    check("tmo no_tx", 64'(txq.size()), 64'(0));
    run_frame("tmo_rd_0001", 1'b0, 1'b0, 14'h0001, 32'h0, 2, 2);

    // A byte landing exactly on the timeout is lost; one cycle earlier it is accepted.
    clear_logs();
    send_gap(8'h80, 2);
    send_gap(8'h00, 2);
    send_gap(8'h55, TMO);
    check("tmo_edge busy", 64'(busy), 64'(0));
    check("tmo_edge overrun", 64'(overrun), 64'(0));
    repeat (3) @(negedge sys_clk);
    check("tmo_edge no_access", 64'(acc_cyc), 64'(0));
    run_frame("rd_gap_max", 1'b0, 1'b1, 14'h0002, 32'h0, TMO - 1, TMO - 1);

    // Byte arriving during a read response is dropped and flagged.
    slave_mem[14'h0123] = 32'hCAFE_F00D;
    exp_mem[14'h0123]   = 32'hCAFE_F00D;
    clear_logs();
    send_gap(8'h01, 2);
    send_gap(8'h23, 3);
    n = 0;
    while (txq.size() == 0 && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("ovr first_tx_seen", 64'(txq.size() != 0), 64'(1));
    send_byte(8'($urandom));
    wait_idle("ovr", 4);
    repeat (3) @(negedge sys_clk);
    check("ovr flag", 64'(overrun), 64'(1));
    check("ovr busy_stays_low", 64'(busy), 64'(0));
    check("ovr tx_count", 64'(txq.size()), 64'(4));
    rd = 32'hCAFE_F00D;
    for (int i = 0; i < 4 && i < txq.size(); i++)
      check("ovr rd_byte", 64'(txq[i]), 64'(rd[8*(3-i) +: 8]));

    // Asynchronous reset in the middle of write data.
    clear_logs();
    send_gap(8'h80, 2);
    send_gap(8'h40, 2);
    send_gap(8'h12, 2);
    send_gap(8'h34, 2);
    #2 sys_rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("rst_mid no_write", 64'(wr_log.size()), 64'(0));
    rd = $urandom;
    run_frame("wr_after_rst", 1'b1, 1'b0, 14'h0040, rd, 2, 4);
    run_frame("rd_after_rst", 1'b0, 1'b0, 14'h0040, 32'h0, 2, 4);

    check("tx_wr_overlap", 64'(tx_overlap), 64'(0));
    check("csr_di_idle", 64'(idle_di_bad), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_csr_bridge.md
UART_CSR_BRIDGE -- requirements
Module: uart_csr_bridge

Interface
REQ-001 Parameter: timeout, default 1000000, idle cycles between command bytes before the parser discards a partial frame.
REQ-002 Port: sys_clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: rx_data  in  8  received byte from the UART transceiver.
REQ-005 Port: rx_done  in  1  one-cycle strobe; rx_data is valid in the same cycle.
REQ-006 Port: tx_data  out  8  byte to transmit.
REQ-007 Port: tx_wr  out  1  one-cycle strobe starting transmission of tx_data.
REQ-008 Port: tx_done  in  1  one-cycle strobe; the previous byte has finished.
REQ-009 Port: csr_a  out  14  CSR address, initiator side.
REQ-010 Port: csr_we  out  1  CSR write strobe.
REQ-011 Port: csr_di  out  32  CSR write data.
REQ-012 Port: csr_do  in  32  CSR read data, valid one cycle after csr_a is presented.
REQ-013 Port: busy  out  1  high in every state except IDLE.
REQ-014 Port: overrun  out  1  sticky flag; set when a byte is dropped.

Function
REQ-015 Frame format: byte0 = {we, x, a[13:8]}, with bit 6 ignored; byte1 = a[7:0]; if we=1, byte0 and byte1 are followed by 4 data bytes, MSB first.
REQ-016 States: IDLE, ADDR, WDATA, CSR_WR, CSR_RD, CSR_CAP, TX_SEND, TX_WAIT.
REQ-017 IDLE, rx_done: latch we and a[13:8]; go to ADDR.
REQ-018 ADDR, rx_done: latch a[7:0]; go to WDATA with byte count 0 if we=1, otherwise to CSR_RD.
REQ-019 WDATA, rx_done: shift the byte into the data register (new byte enters bits 7:0); after the 4th byte go to CSR_WR.
REQ-020 CSR_WR: drive csr_a=address, csr_di=data and csr_we=1 for exactly one cycle; load response byte 8'hAA; go to TX_SEND.
REQ-021 CSR_RD: drive csr_a=address with csr_we=0 for one cycle; go to CSR_CAP.
REQ-022 CSR_CAP: capture csr_do into the response register; set remaining-byte count 4; go to TX_SEND.
REQ-023 TX_SEND: pulse tx_wr for one cycle with tx_data = current response byte (read data MSB first); go to TX_WAIT.
REQ-024 TX_WAIT, tx_done: decrement the remaining-byte count; return to TX_SEND if bytes remain, otherwise go to IDLE.
REQ-025 Outside CSR_WR/CSR_RD: csr_we=0, csr_a=0 and csr_di=0; at most one CSR access per frame.
REQ-026 Read latency: csr_do is sampled exactly one cycle after the cycle in which csr_a is presented.
REQ-027 rx_done in CSR_WR, CSR_RD, CSR_CAP, TX_SEND or TX_WAIT: drop the byte, set overrun, leave the state unchanged.
REQ-028 Timeout: a counter clears on every rx_done and counts in ADDR/WDATA; on reaching timeout-1, return to IDLE without any CSR access; no timeout applies in other states.
REQ-029 rx_done in the same cycle the timeout fires: the timeout wins and the byte is discarded (overrun not set).
REQ-030 tx_done in any state other than TX_WAIT is ignored.
REQ-031 tx_wr is never asserted while a previous byte is unacknowledged.

Reset
REQ-032 Asserting sys_rst_n low, at any time including mid-frame or mid-transmit, immediately forces IDLE, busy=0, overrun=0, tx_wr=0, tx_data=0, csr_we=0, csr_a=0, csr_di=0, and clears the counters and the data register.
REQ-033 After deassertion, the first rx_done is treated as byte0 of a new frame.

Verification
REQ-034 Bytes 0x80,0x04,0x12,0x34,0x56,0x78 -> one-cycle csr_we with csr_a=0x0004 and csr_di=0x12345678; then tx_wr with 0xAA.
REQ-035 Bytes 0x3F,0xFF; csr_do returns 0xDEADBEEF on the cycle after csr_a=0x3FFF -> tx bytes DE, AD, BE, EF, each issued only after tx_done.
REQ-036 timeout=16; send 0x80,0x00,0x11, then idle 20 cycles -> no csr_we, return to IDLE; next bytes 0x00,0x01 -> read of address 0x0001.
REQ-037 During a read response, inject rx_done -> overrun=1; the remaining response bytes are unaffected; busy falls after the 4th tx_done.
REQ-038 Assert sys_rst_n low after the 2nd write-data byte -> all outputs at reset values asynchronously; a following full write frame executes correctly.
